// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard / forwarding controller.
// Scoreboard entry layout and forwarding-select encodings.
package pipe_hazard_ctrl_pkg;

  localparam int NUM_STAGES_DEF = 3;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int REG_ADDR_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF         = 2'd0,
    FWD_STAGE_BASE = 2'd1
  } fwd_sel_t;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_MAX-1:0] dest;
    logic                      is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination shift register for the stages after ID.
// Holds while the pipe is stalled; reports per-operand matches.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  output logic [NUM_STAGES-1:0] match_a,
  output logic [NUM_STAGES-1:0] match_b,
  output logic [NUM_STAGES-1:0] load_vec
);

  sb_entry_t [NUM_STAGES-1:0] sb_q;
  sb_entry_t                  head;

  logic [REG_ADDR_W_MAX-1:0] s1_ext;
  logic [REG_ADDR_W_MAX-1:0] s2_ext;

  assign s1_ext = REG_ADDR_W_MAX'(src1);
  assign s2_ext = REG_ADDR_W_MAX'(src2);

  always_comb begin
    head         = '0;
    head.valid   = issue_valid;
    head.dest    = REG_ADDR_W_MAX'(issue_dest);
    head.is_load = issue_load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q <= '0;
    end else if (!hold) begin
      sb_q[0] <= head;
      for (int i = 1; i < NUM_STAGES; i++)
        sb_q[i] <= sb_q[i-1];
    end
  end

  always_comb begin
    match_a  = '0;
    match_b  = '0;
    load_vec = '0;
    for (int e = 0; e < NUM_STAGES; e++) begin
      match_a[e]  = sb_q[e].valid
                  && (sb_q[e].dest == s1_ext);
      match_b[e]  = sb_q[e].valid && two_src
                  && (sb_q[e].dest == s2_ext);
      load_vec[e] = sb_q[e].is_load;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall control beside the ID stage.
// Youngest-producer forwarding, load-use or full RAW stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int FWD_EN     = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_r,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  freeze,
  output logic                  flush,
  output logic                  bubble,
  output logic                  pipe_stall,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic [31:0]           stall_count
);

  logic [NUM_STAGES-1:0] match_a;
  logic [NUM_STAGES-1:0] match_b;
  logic [NUM_STAGES-1:0] load_vec;
  logic                  raw_hit;
  logic                  hazard;
  logic [31:0]           stall_cnt_q;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .hold        (pipe_stall),
    .issue_valid (id_valid & id_wb_en & ~bubble),
    .issue_dest  (id_dest),
    .issue_load  (id_mem_r),
    .src1        (id_src1),
    .src2        (id_src2),
    .two_src     (id_two_src),
    .match_a     (match_a),
    .match_b     (match_b),
    .load_vec    (load_vec)
  );

  assign pipe_stall = mem_req & ~mem_ready;
  assign flush      = branch_taken & ~pipe_stall;

  always_comb begin
    raw_hit = 1'b0;
    if (FWD_EN != 0)
      raw_hit = (match_a[0] | match_b[0]) & load_vec[0];
    else
      raw_hit = |(match_a | match_b);
  end

  assign hazard = id_valid & ~flush & ~pipe_stall & raw_hit;
  assign freeze = hazard;
  assign bubble = hazard;

  // Scan oldest to youngest so the youngest usable producer wins.
  always_comb begin
    fwd_sel_a = SEL_W'(FWD_RF);
    fwd_sel_b = SEL_W'(FWD_RF);
    if (FWD_EN != 0) begin
      for (int e = NUM_STAGES-1; e >= 0; e--) begin
        if (match_a[e] && !(e == 0 && load_vec[0]))
          fwd_sel_a = SEL_W'(e) + SEL_W'(FWD_STAGE_BASE);
        if (match_b[e] && !(e == 0 && load_vec[0]))
          fwd_sel_b = SEL_W'(e) + SEL_W'(FWD_STAGE_BASE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if ((freeze | pipe_stall) && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl, forwarding and
// no-forwarding builds driven side by side.
module tb_pipe_hazard_ctrl;

  localparam int NS = 3;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       wb;
    logic [3:0] dest;
    logic       mem_r;
    logic       bt;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  typedef struct packed {
    logic        frz;
    logic        fl;
    logic        bub;
    logic        ps;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    exp_t f;
    exp_t n;
  } pair_t;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       l;
  } prod_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_two_src, id_wb_en, id_mem_r;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       branch_taken, mem_req, mem_ready;

  logic        f_freeze, f_flush, f_bubble, f_stall;
  logic [1:0]  f_sa, f_sb;
  logic [31:0] f_cnt;
  logic        n_freeze, n_flush, n_bubble, n_stall;
  logic [1:0]  n_sa, n_sb;
  logic [31:0] n_cnt;

  pipe_hazard_ctrl #(.FWD_EN(1)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r(id_mem_r),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .freeze(f_freeze),
    .flush(f_flush), .bubble(f_bubble),
    .pipe_stall(f_stall), .fwd_sel_a(f_sa),
    .fwd_sel_b(f_sb), .stall_count(f_cnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(0)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r(id_mem_r),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .freeze(n_freeze),
    .flush(n_flush), .bubble(n_bubble),
    .pipe_stall(n_stall), .fwd_sel_a(n_sa),
    .fwd_sel_b(n_sb), .stall_count(n_cnt)
  );

  pair_t       exp_q[$];
  prod_t       hist_f[$];
  prod_t       hist_n[$];
  logic [31:0] cnt_f = 0;
  logic [31:0] cnt_n = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          force_pending = 0;
  logic [31:0] force_val = 0;
  pair_t       mon_p;

  // History is oldest-first; the producer issued k+1 cycles ago
  // (in non-stalled cycles) sits at age k.
  function automatic exp_t predict(input bit fwd, input stim_t s,
                                   input prod_t h[$],
                                   input logic [31:0] cnt);
    exp_t x;
    bit any_hit, load0;
    any_hit = 0;
    load0 = 0;
    x = '0;
    x.ps = s.mem_req && !s.mem_ready;
    x.fl = s.bt && !x.ps;
    for (int k = 0; k < h.size(); k++) begin
      prod_t p;
      bit ha, hb, usable;
      p  = h[h.size()-1-k];
      ha = p.v && p.d == s.src1;
      hb = p.v && s.two && p.d == s.src2;
      usable = !(k == 0 && p.l);
      if (ha || hb) begin
        any_hit = 1;
        if (k == 0 && p.l) load0 = 1;
      end
      if (fwd && ha && usable && x.sa == 0) x.sa = 2'(k + 1);
      if (fwd && hb && usable && x.sb == 0) x.sb = 2'(k + 1);
    end
    x.frz = s.id_valid && !x.fl && !x.ps && (fwd ? load0 : any_hit);
    x.bub = x.frz;
    x.cnt = cnt;
    return x;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] c,
                                       input bit inc);
    if (inc && c != 32'hFFFF_FFFF) return c + 1;
    return c;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t ef, en;
    prod_t pf, pn;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.id_valid;
    id_src1 = s.src1; id_src2 = s.src2;
    id_two_src = s.two; id_wb_en = s.wb;
    id_dest = s.dest; id_mem_r = s.mem_r;
    branch_taken = s.bt; mem_req = s.mem_req;
    mem_ready = s.mem_ready;
    if (force_pending) begin
      dut_f.stall_cnt_q = force_val;
      dut_n.stall_cnt_q = force_val;
      cnt_f = force_val;
      cnt_n = force_val;
      force_pending = 0;
    end
    ef = predict(1'b1, s, hist_f, cnt_f);
    en = predict(1'b0, s, hist_n, cnt_n);
    exp_q.push_back('{f: ef, n: en});
    if (!s.rst) begin
      hist_f.delete();
      hist_n.delete();
      cnt_f = 0;
      cnt_n = 0;
    end else begin
      if (!ef.ps) begin
        pf = '{v: s.id_valid && s.wb && !ef.bub, d: s.dest, l: s.mem_r};
        pn = '{v: s.id_valid && s.wb && !en.bub, d: s.dest, l: s.mem_r};
        hist_f.push_back(pf);
        hist_n.push_back(pn);
      end
      while (hist_f.size() > NS) void'(hist_f.pop_front());
      while (hist_n.size() > NS) void'(hist_n.pop_front());
      cnt_f = bump(cnt_f, ef.frz || ef.ps);
      cnt_n = bump(cnt_n, en.frz || en.ps);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_p = exp_q.pop_front();
      check("f.freeze", 32'(f_freeze), 32'(mon_p.f.frz));
      check("f.flush", 32'(f_flush), 32'(mon_p.f.fl));
      check("f.bubble", 32'(f_bubble), 32'(mon_p.f.bub));
      check("f.stall", 32'(f_stall), 32'(mon_p.f.ps));
      check("f.sel_a", 32'(f_sa), 32'(mon_p.f.sa));
      check("f.sel_b", 32'(f_sb), 32'(mon_p.f.sb));
      check("f.count", f_cnt, mon_p.f.cnt);
      check("n.freeze", 32'(n_freeze), 32'(mon_p.n.frz));
      check("n.flush", 32'(n_flush), 32'(mon_p.n.fl));
      check("n.bubble", 32'(n_bubble), 32'(mon_p.n.bub));
      check("n.stall", 32'(n_stall), 32'(mon_p.n.ps));
      check("n.sel_a", 32'(n_sa), 32'(mon_p.n.sa));
      check("n.sel_b", 32'(n_sb), 32'(mon_p.n.sb));
      check("n.count", n_cnt, mon_p.n.cnt);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1;
    s.mem_ready = 1;
    return s;
  endfunction

  function automatic stim_t op(input logic [3:0] d, input logic [3:0] a,
                               input logic [3:0] b, input bit ld);
    stim_t s;
    s = idle();
    s.id_valid = 1; s.wb = 1; s.two = 1;
    s.dest = d; s.src1 = a; s.src2 = b; s.mem_r = ld;
    return s;
  endfunction

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 3);
    return (r == 3) ? 4'd15 : 4'(r);
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst = ($urandom_range(0, 63) != 0);
    s.id_valid = ($urandom_range(0, 3) != 0);
    s.src1 = rreg(); s.src2 = rreg(); s.dest = rreg();
    s.two = $urandom_range(0, 1);
    s.wb = ($urandom_range(0, 3) != 0);
    s.mem_r = ($urandom_range(0, 2) == 0);
    s.bt = ($urandom_range(0, 7) == 0);
    s.mem_req = ($urandom_range(0, 3) == 0);
    s.mem_ready = $urandom_range(0, 1);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 0; id_valid = 0; id_src1 = 0; id_src2 = 0;
    id_two_src = 0; id_wb_en = 0; id_dest = 0; id_mem_r = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    s = idle(); s.rst = 0;
    cyc(s);
    cyc(idle());
    // ADD R1 ; ADD R2,R1 held in ID
    cyc(op(4'd1, 4'd8, 4'd9, 0));
    repeat (4) cyc(op(4'd2, 4'd1, 4'd10, 0));
    repeat (3) cyc(idle());
    // LDR R3 ; SUB R4,R3,R5
    cyc(op(4'd3, 4'd8, 4'd8, 1));
    repeat (2) cyc(op(4'd4, 4'd3, 4'd5, 0));
    // memory wait for 4 cycles with a dependent op in ID
    s = op(4'd6, 4'd4, 4'd3, 0);
    s.mem_req = 1; s.mem_ready = 0;
    repeat (4) cyc(s);
    s.mem_ready = 1;
    cyc(s);
    repeat (3) cyc(idle());
    // branch with load-use, then branch under memory stall
    cyc(op(4'd6, 4'd8, 4'd8, 1));
    s = op(4'd7, 4'd9, 4'd6, 0);
    s.bt = 1;
    cyc(s);
    s.mem_req = 1; s.mem_ready = 0;
    repeat (2) cyc(s);
    s.mem_ready = 1;
    cyc(s);
    repeat (3) cyc(idle());
    // reset while frozen
    cyc(op(4'd7, 4'd8, 4'd8, 1));
    s = op(4'd9, 4'd7, 4'd7, 0);
    cyc(s);
    s.rst = 0;
    cyc(s);
    cyc(op(4'd9, 4'd7, 4'd7, 0));
    // register 15 is tracked
    cyc(op(4'd15, 4'd1, 4'd2, 1));
    repeat (2) cyc(op(4'd3, 4'd1, 4'd15, 0));
    repeat (3) cyc(idle());
    // counter saturation
    force_val = 32'hFFFF_FFFE;
    force_pending = 1;
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (3) cyc(s);
    cyc(idle());
    s = idle(); s.rst = 0;
    cyc(s);
    repeat (400) cyc(rnd());
    @(negedge clk);
    @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
